// File: rtl/l2_data_array_nway.sv
// N-way byte-maskable L2 data store: registered read with write-first bypass,
// and an internal sweep that zeroes every line after reset or on clear.
module l2_data_array_nway #(
    parameter int s_index  = 3,
    parameter int s_offset = 5,
    parameter int num_ways = 4,
    localparam int num_sets = 2**s_index,
    localparam int s_mask   = 2**s_offset,
    localparam int s_line   = 8*s_mask,
    localparam int s_way    = $clog2(num_ways)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    output logic                busy,
    input  logic                read,
    input  logic [s_way-1:0]    rway,
    input  logic [s_index-1:0]  rindex,
    input  logic [s_mask-1:0]   write_en,
    input  logic [s_way-1:0]    wway,
    input  logic [s_index-1:0]  windex,
    input  logic [s_line-1:0]   datain,
    output logic [s_line-1:0]   dataout,
    output logic                dout_valid
);

    typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_t;

    localparam logic [s_index-1:0] last_set = s_index'(num_sets - 1);

    state_t               state_reg, state_next;
    logic [s_index-1:0]   sweep_cnt_reg, sweep_cnt_next;
    logic                 sweep_we;
    logic                 read_accept;
    logic                 write_accept;
    logic                 bypass_hit;
    logic [s_line-1:0]    way_rdata [num_ways];
    logic [s_line-1:0]    rd_line;
    logic [s_line-1:0]    rd_merged;
    logic [s_line-1:0]    dataout_reg;
    logic                 dout_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SWEEP;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    // The counter wraps to 0 on the final sweep edge, ready for the next clear.
    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            SWEEP: begin
                sweep_cnt_next = sweep_cnt_reg + s_index'(1);
                if (sweep_cnt_reg == last_set) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (clear) begin
                    state_next     = SWEEP;
                    sweep_cnt_next = '0;
                end
            end
            default: begin
                state_next     = SWEEP;
                sweep_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        busy         = 1'b1;
        sweep_we     = 1'b0;
        read_accept  = 1'b0;
        write_accept = 1'b0;
        case (state_reg)
            SWEEP: sweep_we = 1'b1;
            READY: begin
                busy         = 1'b0;
                read_accept  = read & ~clear;
                write_accept = (|write_en) & ~clear;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
        localparam int unsigned way_id = gi;
        logic [s_line-1:0] mem [num_sets];
        logic              way_we;

        assign way_we = write_accept && (wway == way_id[s_way-1:0]);

        always_ff @(posedge clk) begin
            if (sweep_we) begin
                mem[sweep_cnt_reg] <= '0;
            end else if (way_we) begin
                for (int b = 0; b < s_mask; b++) begin
                    if (write_en[b]) begin
                        mem[windex][8*b +: 8] <= datain[8*b +: 8];
                    end
                end
            end
        end

        assign way_rdata[gi] = mem[rindex];
    end

    assign rd_line    = way_rdata[rway];
    assign bypass_hit = write_accept && (wway == rway) && (windex == rindex);

    // Write-first: enabled bytes of a colliding write replace the stored bytes.
    for (genvar gi = 0; gi < s_mask; gi++) begin : g_byte
        assign rd_merged[8*gi +: 8] = (bypass_hit && write_en[gi]) ? datain[8*gi +: 8]
                                                                   : rd_line[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_reg    <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= read_accept;
            dataout_reg    <= read_accept ? rd_merged : '0;
        end
    end

    assign dataout    = dataout_reg;
    assign dout_valid = dout_valid_reg;

endmodule

// File: doc/l2_data_array_nway.md
# l2_data_array_nway

N-way, byte-maskable L2 data store with a registered read port, same-cycle write-to-read bypass, and a hardware clear sequencer. It replaces the single-way combinational-read data array in the L2 cache datapath: the L2 controller writes fills and write-backs through the write port and reads hit lines one cycle after request. Array contents are cleared by an internal sweep after reset or on request, so no reset fan-out to the storage is needed.

## Interface
- s_index, 3, set-index width; num_sets = 2**s_index
- s_offset, 5, byte-offset width; s_mask = 2**s_offset bytes per line, s_line = 8*s_mask bits
- num_ways, 4, ways per set; power of two, >= 2; s_way = $clog2(num_ways)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  start a zeroing sweep of all sets and ways (level, sampled when not busy)
- busy  out  1  sweep in progress; read and write ignored
- read  in  1  read request
- rway  in  s_way  read way select
- rindex  in  s_index  read set index
- write_en  in  s_mask  per-byte write enable
- wway  in  s_way  write way select
- windex  in  s_index  write set index
- datain  in  s_line  write data
- dataout  out  s_line  registered read data; zero when dout_valid=0
- dout_valid  out  1  dataout holds the response to the read accepted on the previous edge

## Operation
- Storage: num_ways x num_sets lines of s_line bits; no reset on the storage itself.
- FSM states: SWEEP, READY.
- rst_n low (async): state=SWEEP, sweep counter=0, busy=1, dout_valid=0, dataout=0. Reset mid-sweep restarts from set 0.
- SWEEP: each edge writes zeros to set[counter] in every way, counter++. The edge that writes set num_sets-1 moves to READY and wraps counter to 0. read and write_en are ignored; dout_valid=0.
- READY, clear=1: clear has priority. Same-edge read and write are dropped; next state SWEEP, counter=0.
- READY, write: for each byte i with write_en[i]=1, line[wway][windex] byte i <= datain byte i; other bytes unchanged. write_en=0 means no write.
- READY, read=1: on the edge, dataout <= line[rway][rindex], dout_valid <= 1. Bypass applies when the same edge also writes with wway==rway and windex==rindex: byte i comes from datain where write_en[i]=1, otherwise from storage (write-first).
- READY, read=0: dout_valid <= 0, dataout <= 0.
- Read and write to different way/index in the same cycle are independent; both complete.
- A write to another way of the same index never affects the read result.

## Timing
- Read latency is 1 cycle: request sampled at edge N, data and dout_valid valid after edge N, held through edge N+1.
- Back-to-back reads give one result per cycle. dout_valid is high for exactly one cycle per accepted read.
- A write is visible to a read accepted on the same edge (bypass) and to any later read.
- Sweep length: busy stays high for exactly num_sets rising edges after rst_n deasserts or after the clear-accepting edge. For clear, busy rises on the edge that accepts clear. The first read can be accepted on the edge after busy falls.
- busy is a registered output: 1 during reset, 0 only in READY.
- No back-pressure: the requester must not issue read or write while busy=1. Any such request is silently dropped.

## Test plan
- Reset sweep: deassert rst_n -> busy=1 for exactly 8 edges (s_index=3), then 0. Reading every way/index returns 0 with dout_valid=1 one cycle after each request.
- Byte-masked write then read: write way 2 idx 5, datain all 0xA5, write_en=0x0000_FFFF; read way 2 idx 5 next cycle -> low 16 bytes 0xA5, upper 16 bytes 0. Ways 0/1/3 idx 5 still read 0.
- Same-cycle bypass: line already holds 0x11 per byte; in one cycle write way 1 idx 3 with 0x22 per byte, write_en=0x0000_000F, and read way 1 idx 3 -> bytes 0-3 = 0x22, bytes 4-31 = 0x11. Write to way 0 same idx with the read of way 1 -> read returns the old way-1 data.
- Back-to-back reads idx 0..7 on consecutive cycles -> 8 consecutive dout_valid=1 cycles with correct data in order. dout_valid drops the cycle after read falls.
- clear with simultaneous read and write in READY -> the write is not performed and dout_valid stays 0. busy=1 for 8 cycles, then all lines read 0.
- Async reset mid-sweep (assert rst_n low at sweep cycle 4, release) -> outputs go to 0 immediately, busy=1. The sweep restarts and busy is high for a full 8 edges.
